time_entry_ctrl: RTL and testbench

//  Input-side counterpart of the display path: turns raw user switches and the set

---
 rtl/time_entry_ctrl.sv | 146 ++++++++++++++
 tb/tb_time_entry_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/time_entry_ctrl.sv
// Set-button driven time entry: synchronises and debounces the button, then collects
// hour, minute and second from the switches and emits a load pulse for clock or alarm.
module time_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  switches,
  input  logic        button,
  output logic [16:0] time_out,
  output logic        load_time,
  output logic        load_alarm,
  output logic [1:0]  field_sel,
  output logic        blink
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;

  // Switch bits [7:6] carry no meaning; only target and field value are synchronised.
  logic [1:0]    sw_unused;
  logic [6:0]    sw_meta, sw_sync;
  logic          btn_meta, btn_sync;
  logic [DW-1:0] db_cnt;
  logic          stable, stable_q, press;

  state_t        state;
  logic          target;
  logic [4:0]    hh_scr;
  logic [5:0]    mm_scr, ss_scr;
  logic [TW-1:0] idle_cnt;
  logic          expired;
  logic [4:0]    hh_clamp;
  logic [5:0]    ms_clamp;

  assign sw_unused = switches[7:6];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      db_cnt   <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      sw_meta  <= {switches[8], switches[5:0]};
      sw_sync  <= sw_meta;
      stable_q <= stable;
      press    <= stable & ~stable_q;
      if (btn_sync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        stable <= ~stable;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign expired  = (idle_cnt == TO_LAST);
  assign hh_clamp = (sw_sync[4:0] > 5'd23) ? 5'd23 : sw_sync[4:0];
  assign ms_clamp = (sw_sync[5:0] > 6'd59) ? 6'd59 : sw_sync[5:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      target     <= 1'b0;
      hh_scr     <= '0;
      mm_scr     <= '0;
      ss_scr     <= '0;
      idle_cnt   <= '0;
      time_out   <= '0;
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
      field_sel  <= 2'd0;
      blink      <= 1'b0;
    end else begin
      load_time  <= 1'b0;
      load_alarm <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            target    <= sw_sync[6];
            idle_cnt  <= '0;
            state     <= SET_HOUR;
            field_sel <= 2'd1;
            blink     <= 1'b1;
          end
        end
        SET_HOUR, SET_MIN, SET_SEC: begin
          // A press takes priority over an expiring idle count in the same cycle.
          if (press) begin
            idle_cnt <= '0;
            case (state)
              SET_HOUR: begin
                hh_scr    <= hh_clamp;
                state     <= SET_MIN;
                field_sel <= 2'd2;
              end
              SET_MIN: begin
                mm_scr    <= ms_clamp;
                state     <= SET_SEC;
                field_sel <= 2'd3;
              end
              default: begin
                ss_scr    <= ms_clamp;
                state     <= COMMIT;
                field_sel <= 2'd0;
                blink     <= 1'b0;
              end
            endcase
          end else if (expired) begin
            state     <= IDLE;
            field_sel <= 2'd0;
            blink     <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        COMMIT: begin
          time_out   <= {hh_scr, mm_scr, ss_scr};
          load_time  <= ~target;
          load_alarm <= target;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          field_sel <= 2'd0;
          blink     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: directed button/switch sequences checked every cycle
// against a behavioural model, plus literal expectations after each scenario.
module tb_time_entry_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned TO = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  switches = '0;
  logic        button = 1'b0;
  logic [16:0] time_out;
  logic        load_time, load_alarm;
  logic [1:0]  field_sel;
  logic        blink;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_lt = 0;
  int unsigned n_la = 0;

  time_entry_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .switches(switches), .button(button),
    .time_out(time_out), .load_time(load_time), .load_alarm(load_alarm),
    .field_sel(field_sel), .blink(blink)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: raw button history decides the accepted level; entry progress is a step number
  // 0=idle, 1..3=field being entered, 4=commit.
  bit          rq[$];
  logic [8:0]  swq[$];
  bit          m_stable, m_rose, m_press, m_lt, m_la, p, all_diff;
  int          m_step, m_t, m_hh, m_mm, m_ss;
  bit          m_target;
  logic [16:0] m_time;
  logic [8:0]  sw;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rq = {};
      for (int i = 0; i <= DB; i++) rq.push_front(1'b0);
      swq = {9'd0, 9'd0};
      m_stable = 0; m_rose = 0; m_press = 0; m_lt = 0; m_la = 0;
      m_step = 0; m_t = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_target = 0; m_time = '0;
    end else begin
      p  = m_press;
      sw = swq[1];
      all_diff = 1;
      for (int i = 1; i <= DB; i++) if (rq[i] == m_stable) all_diff = 0;
      m_press = m_rose;
      m_rose  = 0;
      if (all_diff) begin
        m_stable = ~m_stable;
        m_rose   = m_stable;
      end
      m_lt = 0;
      m_la = 0;
      case (m_step)
        0: if (p) begin m_target = sw[8]; m_step = 1; m_t = 0; end
        1, 2, 3: begin
          if (p) begin
            if (m_step == 1) m_hh = (sw[4:0] > 23) ? 23 : int'(sw[4:0]);
            else if (m_step == 2) m_mm = (sw[5:0] > 59) ? 59 : int'(sw[5:0]);
            else m_ss = (sw[5:0] > 59) ? 59 : int'(sw[5:0]);
            m_step++;
            m_t = 0;
          end else if (m_t == TO - 1) m_step = 0;
          else m_t++;
        end
        default: begin
          m_time = {5'(m_hh), 6'(m_mm), 6'(m_ss)};
          if (m_target) m_la = 1; else m_lt = 1;
          m_step = 0;
        end
      endcase
      rq.push_front(button);
      void'(rq.pop_back());
      swq.push_front(switches);
      void'(swq.pop_back());
    end
  end

  always @(negedge clock) begin
    if (load_time) n_lt++;
    if (load_alarm) n_la++;
    if (!reset) begin
      check("time_out", 32'(time_out), 32'(m_time));
      check("load_time", 32'(load_time), 32'(m_lt));
      check("load_alarm", 32'(load_alarm), 32'(m_la));
      check("field_sel", 32'(field_sel), (m_step >= 1 && m_step <= 3) ? m_step : 0);
      check("blink", 32'(blink), (m_step >= 1 && m_step <= 3) ? 1 : 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [8:0] v);
    switches = v;
    cycles(2);
    button = 1'b1;
    cycles(10);
    button = 1'b0;
    cycles(10);
  endtask

  initial begin
    cycles(3);
    reset = 1'b0;
    cycles(1);
    check("reset_time_out", 32'(time_out), 0);
    check("reset_field_sel", 32'(field_sel), 0);

    // Bounce: runs of 2 never reach the debounce count, then a clean hold.
    for (int i = 0; i < 10; i++) begin
      button = ~button;
      cycles(2);
    end
    button = 1'b1;
    cycles(10);
    button = 1'b0;
    cycles(10);
    check("bounce_field_sel", 32'(field_sel), 1);
    check("bounce_blink", 32'(blink), 1);

    press(9'd13);
    press(9'd45);
    press(9'd7);
    check("entry_time_out", 32'(time_out), 32'h0DB47);
    check("entry_load_time_count", n_lt, 1);
    check("entry_load_alarm_count", n_la, 0);
    check("entry_field_sel", 32'(field_sel), 0);

    press(9'h100);
    press(9'h100 | 9'd31);
    press(9'h100 | 9'd63);
    press(9'h100 | 9'd60);
    check("clamp_time_out", 32'(time_out), 32'h17EFB);
    check("clamp_load_alarm_count", n_la, 1);
    check("clamp_load_time_count", n_lt, 1);

    press(9'd0);
    press(9'd5);
    check("timeout_in_set_min", 32'(field_sel), 2);
    cycles(70);
    check("timeout_field_sel", 32'(field_sel), 0);
    check("timeout_time_out", 32'(time_out), 32'h17EFB);
    check("timeout_no_load", n_lt + n_la, 2);

    press(9'd0);
    press(9'd1);
    press(9'd2);
    check("pre_reset_field_sel", 32'(field_sel), 3);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {time_out, load_time, load_alarm, field_sel, blink}, 0);
    cycles(2);
    reset = 1'b0;
    press(9'd0);
    check("after_reset_field_sel", 32'(field_sel), 1);
    cycles(70);
    check("after_reset_timeout", 32'(field_sel), 0);

    press(9'd0);
    press(9'd5);
    press(9'h100 | 9'd30);
    press(9'h100 | 9'd9);
    check("target_latch_time_out", 32'(time_out), 32'h05789);
    check("target_latch_load_time", n_lt, 2);
    check("target_latch_load_alarm", n_la, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
